// File: rtl/sub_pkg.sv
// Shared definitions for the pipelined subtractor: stage count helper, stage record, default chunk width.
// Optional build macro SUB_SAT_EN (used by pipe_subtractor) clamps underflowing results to zero.
package sub_pkg;

    localparam int SUB_CHUNK_W = 4;
    localparam int SUB_MAX_W   = 64;

    // Fields are sized for the widest supported operand; narrower instances leave the top bits at zero.
    typedef struct packed {
        logic                 valid;
        logic [SUB_MAX_W-1:0] a_rem;
        logic [SUB_MAX_W-1:0] b_rem;
        logic [SUB_MAX_W-1:0] diff_acc;
        logic                 borrow;
    } stage_rec_t;

    function automatic int sub_stages(input int width, input int chunk);
        if (chunk < 1) begin
            return 1;
        end
        return (width / chunk < 1) ? 1 : width / chunk;
    endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational CHUNK-bit borrow-ripple slice: d = a - b - bin, bout = borrow out of the top bit.
module sub_chunk
    import sub_pkg::*;
#(
    parameter int CHUNK = SUB_CHUNK_W
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    logic [CHUNK:0] br;

    always_comb begin
        br    = '0;
        d     = '0;
        br[0] = bin;
        for (int i = 0; i < CHUNK; i++) begin
            d[i]    = a[i] ^ b[i] ^ br[i];
            br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
        end
    end

    assign bout = br[CHUNK];

endmodule

// File: rtl/pipe_subtractor.sv
// Pipelined unsigned subtractor, one CHUNK-bit slice per stage with a globally stalled valid/ready pipe.
// Build macro SUB_SAT_EN: when defined, an underflowing result is clamped to zero at the last stage.
module pipe_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = SUB_CHUNK_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow
);

    localparam int CW     = (CHUNK < 1) ? 1 : CHUNK;
    localparam int STAGES = sub_stages(WIDTH, CW);

    if ((CHUNK < 1) || (WIDTH < 1) || (WIDTH % CW != 0) || (WIDTH > SUB_MAX_W)) begin : g_bad_params
        $error("pipe_subtractor: WIDTH must be a positive multiple of CHUNK (CHUNK >= 1, WIDTH <= %0d)", SUB_MAX_W);
    end

    stage_rec_t stage_reg [STAGES];
    logic       adv;

    // A single advance signal freezes every stage together, so bubbles are never collapsed.
    assign adv        = ~stage_reg[STAGES-1].valid | out_ready;
    assign in_ready   = adv;
    assign out_valid  = stage_reg[STAGES-1].valid;
    assign out_diff   = stage_reg[STAGES-1].diff_acc[WIDTH-1:0];
    assign out_borrow = stage_reg[STAGES-1].borrow;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        stage_rec_t    src;
        stage_rec_t    rec_next;
        logic [CW-1:0] d_c;
        logic          bo_c;
        logic          unused_rec;

        // Stage 0 sees the raw operands; later stages see the skewed remainder left by their predecessor.
        if (gi == 0) begin : g_src_in
            always_comb begin
                src                    = '0;
                src.valid              = in_valid;
                src.a_rem[WIDTH-1:0]   = in_a;
                src.b_rem[WIDTH-1:0]   = in_b;
                src.borrow             = in_bin;
            end
        end else begin : g_src_prev
            assign src = stage_reg[gi-1];
        end

        sub_chunk #(
            .CHUNK (CW)
        ) u_chunk (
            .a    (src.a_rem[CW-1:0]),
            .b    (src.b_rem[CW-1:0]),
            .bin  (src.borrow),
            .d    (d_c),
            .bout (bo_c)
        );

        always_comb begin
            rec_next                      = src;
            rec_next.a_rem                = src.a_rem >> CW;
            rec_next.b_rem                = src.b_rem >> CW;
            rec_next.diff_acc[gi*CW +: CW] = d_c;
            rec_next.borrow               = bo_c;
`ifdef SUB_SAT_EN
            if ((gi == STAGES - 1) && bo_c) begin
                rec_next.diff_acc = '0;
            end
`endif
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_reg[gi] <= '0;
            end else if (adv) begin
                stage_reg[gi] <= rec_next;
            end
        end

        // Upper record bits beyond WIDTH and the last stage's exhausted remainders are intentionally dead.
        assign unused_rec = ^stage_reg[gi];
    end

endmodule

// File: tb/tb_pipe_subtractor.sv
// Directed self-checking bench for pipe_subtractor (WIDTH=16, CHUNK=4, 4 stages).
module tb_pipe_subtractor;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_borrow;

    int errors = 0;
    int checks = 0;

    pipe_subtractor #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_bin     (in_bin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_diff   (out_diff),
        .out_borrow (out_borrow)
    );

    always #5 clk = ~clk;

    task automatic to_post();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic bin);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_bin   = bin;
    endtask

    // Hand-computed wrapped difference turned into what the build should present.
    function automatic logic [15:0] shown(input logic [15:0] wrapped, input logic bo);
`ifdef SUB_SAT_EN
        return bo ? 16'h0000 : wrapped;
`else
        return wrapped;
`endif
    endfunction

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 16'hBEEF, 16'h1234, 1'b1);
        for (int c = 0; c < 3; c++) begin
            to_neg();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_out_valid c=%0d got=%b want=0", c, out_valid);
            end
            checks++;
            if (out_diff !== 16'h0000 || out_borrow !== 1'b0) begin
                errors++;
                $display("FAIL reset_data c=%0d got=%h/%b want=0000/0", c, out_diff, out_borrow);
            end
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready c=%0d got=%b want=1", c, in_ready);
            end
            to_post();
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        rst = 1'b0;
        to_neg();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got=%b want=0", out_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_ops();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic        vi [3];
        logic [15:0] vd [3];
        logic        vo [3];
        va = '{16'h1234, 16'h0000, 16'hFFFF};
        vb = '{16'h0234, 16'h0001, 16'h0000};
        vi = '{1'b0, 1'b0, 1'b1};
        vd = '{16'h1000, 16'hFFFF, 16'hFFFE};
        vo = '{1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            to_post();
            drive(1'b1, va[k], vb[k], vi[k]);
            for (int n = 1; n <= 4; n++) begin
                to_post();
                if (n == 1) drive(1'b0, 16'h0, 16'h0, 1'b0);
                to_neg();
                checks++;
                if (n < 4) begin
                    if (out_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL single_early k=%0d n=%0d got=%b want=0", k, n, out_valid);
                    end
                end else if (out_valid !== 1'b1 || out_diff !== shown(vd[k], vo[k]) || out_borrow !== vo[k]) begin
                    errors++;
                    $display("FAIL single_result k=%0d got=%b/%h/%b want=1/%h/%b",
                             k, out_valid, out_diff, out_borrow, shown(vd[k], vo[k]), vo[k]);
                end
            end
            $display("single op %h - %h - %b -> %h borrow %b", va[k], vb[k], vi[k], out_diff, out_borrow);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ed [8];
        ed = '{16'h0000, 16'h110F, 16'h2220, 16'h332F, 16'h4440, 16'h554F, 16'h6660, 16'h776F};
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            to_post();
            if (c < 8) drive(1'b1, 16'(c * 16'h1111), 16'(c), c[0]);
            else       drive(1'b0, 16'h0, 16'h0, 1'b0);
            to_neg();
            checks++;
            if (out_valid !== ((c >= 4) && (c < 12))) begin
                errors++;
                $display("FAIL b2b_valid c=%0d got=%b want=%b", c, out_valid, (c >= 4) && (c < 12));
            end
            if (c >= 4 && c < 12) begin
                checks++;
                if (out_diff !== ed[c-4] || out_borrow !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_data i=%0d got=%h/%b want=%h/0", c - 4, out_diff, out_borrow, ed[c-4]);
                end
                $display("b2b result %0d: %h borrow %b", c - 4, out_diff, out_borrow);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] va [5];
        logic [15:0] vb [5];
        logic        vi [5];
        logic [15:0] vd [5];
        logic        vo [5];
        logic [15:0] held_d;
        logic        held_b;
        logic        have_hold;
        int          idx;
        int          oidx;
        int          c;
        va = '{16'h8000, 16'h0010, 16'hFFFF, 16'hABCD, 16'h0F0F};
        vb = '{16'h0001, 16'h0020, 16'hFFFF, 16'h1234, 16'h00F0};
        vi = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vd = '{16'h7FFF, 16'hFFF0, 16'hFFFF, 16'h9998, 16'h0E1F};
        vo = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        idx       = 0;
        oidx      = 0;
        c         = 0;
        have_hold = 1'b0;
        held_d    = '0;
        held_b    = 1'b0;
        while (oidx < 5 && c < 40) begin
            to_post();
            out_ready = (c >= 7);
            if (idx < 5) drive(1'b1, va[idx], vb[idx], vi[idx]);
            else         drive(1'b0, 16'h0, 16'h0, 1'b0);
            to_neg();
            if (c == 4) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_full got=%b want=1", out_valid);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b0) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready c=%0d got=%b want=0", c, in_ready);
                end
                if (have_hold) begin
                    checks++;
                    if (out_diff !== held_d || out_borrow !== held_b) begin
                        errors++;
                        $display("FAIL stall_stable c=%0d got=%h/%b want=%h/%b", c, out_diff, out_borrow, held_d, held_b);
                    end
                end else begin
                    held_d    = out_diff;
                    held_b    = out_borrow;
                    have_hold = 1'b1;
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (out_diff !== shown(vd[oidx], vo[oidx]) || out_borrow !== vo[oidx]) begin
                    errors++;
                    $display("FAIL stall_data i=%0d got=%h/%b want=%h/%b",
                             oidx, out_diff, out_borrow, shown(vd[oidx], vo[oidx]), vo[oidx]);
                end
                $display("stall result %0d: %h borrow %b", oidx, out_diff, out_borrow);
                oidx++;
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) idx++;
            c++;
        end
        checks++;
        if (oidx != 5) begin
            errors++;
            $display("FAIL stall_delivered got=%0d want=5", oidx);
        end
        for (int k = 0; k < 4; k++) begin
            to_post();
            drive(1'b0, 16'h0, 16'h0, 1'b0);
            to_neg();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_duplicate k=%0d got=%b want=0", k, out_valid);
            end
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            to_post();
            drive(1'b1, 16'(16'h5555 + c), 16'h1111, 1'b0);
        end
        to_post();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        rst = 1'b1;
        to_neg();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_valid got=%b want=0", out_valid);
        end
        to_post();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            to_neg();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_stale k=%0d got=%b/%h want=0", k, out_valid, out_diff);
            end
            to_post();
        end
        drive(1'b1, 16'h00FF, 16'h000F, 1'b0);
        for (int n = 1; n <= 4; n++) begin
            to_post();
            if (n == 1) drive(1'b0, 16'h0, 16'h0, 1'b0);
            to_neg();
            checks++;
            if (n < 4) begin
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL midrst_early n=%0d got=%b want=0", n, out_valid);
                end
            end else if (out_valid !== 1'b1 || out_diff !== 16'h00F0 || out_borrow !== 1'b0) begin
                errors++;
                $display("FAIL midrst_new got=%b/%h/%b want=1/00f0/0", out_valid, out_diff, out_borrow);
            end
        end
        $display("post-reset op 00ff - 000f -> %h borrow %b", out_diff, out_borrow);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        test_reset();
        test_single_ops();
        test_back_to_back();
        test_stall();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
